fft_frame_streamer: RTL and testbench
=====================================

// Module: fft_frame_streamer
// PURPOSE
//  Synthesizable, parametrised frame source that feeds the multimode FFT input port (stb/sop_in/x_re/x_im/inv/np).
//  Host preloads one frame of complex samples into an internal RAM, then plays 1..2^REP_W-1 frames (or runs continuously).
//  Frame length is selected by np, and inter-frame gaps are programmable. Streaming uses a valid/ready handshake.
//  Sits between the host/test register block and fft_multimode, and replaces the bench-only stimulus loop for on-chip self-test.
// PARAMETERS
//  DW         16  sample width per component (re, im), two's complement
//  NP_W       2   width of np; frame length N = 2^(BASE_LOG2N+np)
//  BASE_LOG2N 6   log2 of the shortest frame (np=0 -> 64, np=3 -> 512)
//  REP_W      8   width of repeat count
//  GAP_W      8   width of inter-frame gap count
//  localparam MAX_LOG2N = BASE_LOG2N + 2^NP_W - 1 (RAM depth 2^MAX_LOG2N)
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          asynchronous, active-high reset
//  ld_en      in   1          write ld_re/ld_im to RAM[ld_addr]; ignored while busy
//  ld_addr    in   MAX_LOG2N  load address
//  ld_re      in   DW         load sample, real
//  ld_im      in   DW         load sample, imag
//  start      in   1          pulse; latches cfg and begins playback; ignored while busy
//  abort      in   1          stops playback; has priority over start
//  np_cfg     in   NP_W       frame-size select
//  inv_cfg    in   1          inverse-FFT flag to pass through
//  rep_cfg    in   REP_W      number of frames; 0 = continuous until abort
//  gap_cfg    in   GAP_W      idle cycles between the eop beat and the next sop beat
//  ready      in   1          downstream can accept a beat
//  stb        out  1          beat valid
//  sop_in     out  1          first beat of frame (qualified by stb)
//  eop        out  1          last beat of frame (qualified by stb)
//  x_re       out  DW         sample, real
//  x_im       out  DW         sample, imag
//  inv        out  1          latched inv_cfg, constant while busy
//  np         out  NP_W       latched np_cfg, constant while busy
//  busy       out  1          playback in progress
//  done       out  1          one-cycle pulse after the final frame's eop beat transfers
//  frame_cnt  out  REP_W      frames completed since start (wraps at 2^REP_W)
// BEHAVIOUR
//  Reset: stb, sop_in, eop, busy, done = 0; x_re, x_im, frame_cnt, inv, np = 0; FSM = IDLE.
//  Beat transfers on a rising edge when stb && ready. While stb && !ready, x_*, sop_in and eop hold stable.
//  stb never drops without a transfer, except on abort or rst.
//  FSM states:
//   IDLE   start -> latch cfg, clear frame_cnt, issue RAM read at addr 0 -> PRIME; busy=1 from next cycle.
//   PRIME  one cycle (RAM read latency 1) -> STREAM; stb rises 2 cycles after the start edge.
//   STREAM address counter advances on every transfer.
//          Read-ahead with a 2-entry skid keeps full throughput when ready=1 (one beat per cycle).
//          sop_in on addr 0; eop on addr N-1.
//          eop transfer: frame_cnt++; if last frame (frame_cnt+1 == rep_cfg, rep_cfg != 0) -> IDLE with done=1 next cycle, busy=0.
//          Otherwise, gap=0 -> next frame's sop beat presented the following cycle (back-to-back); else -> GAP.
//   GAP    stb=0 for exactly gap_cfg cycles (prefetch of addr 0 overlaps) -> STREAM.
//  abort (any state): next edge stb/sop_in/eop = 0, busy=0, FSM=IDLE, no done pulse; frame_cnt holds.
//  start && abort same cycle: abort wins, nothing starts.
//  Config inputs are sampled only at the accepted start; later changes have no effect until the next start.
//  RAM address bits above log2(N) are forced 0 during playback; samples N..max are never read.
//  ld_en while busy is dropped (no write), so playback data is never corrupted.
//  rst asserted mid-frame: all outputs go to reset values asynchronously; RAM contents are not guaranteed.
// STRUCTURE
//  Package fft_stream_pkg holds:
//   - state enum {IDLE, PRIME, STREAM, GAP}
//   - function frame_len(np) = 1 << (BASE_LOG2N+np)
//   - shared defaults for DW, NP_W, BASE_LOG2N
//  Sub-module fft_sample_ram: simple dual-port RAM, 2^MAX_LOG2N x 2*DW, registered read, 1-cycle latency.
//  FSM, counters and skid buffer live in the top module.
// TESTING
//  1 Load ramp re=i, im=-i (512), np=3, rep=1, gap=0, ready=1, start -> stb high 2 cycles later for 512 contiguous beats;
//    sop_in with x_re=0x0000; eop with x_re=0x01FF, x_im=0xFE01; done 1 cycle later; frame_cnt=1.
//  2 Same as 1 with ready random 50% -> identical 512-beat sequence, no drop/dup, outputs stable during every stall.
//  3 np=0, rep=3, gap=4 -> three 64-beat frames, exactly 4 idle cycles between each eop and next sop,
//    frame_cnt 1,2,3, single done.
//  4 np=1, rep=0, gap=0, ready=1, abort after 1000 beats -> beat 1000 values wrap mod 128 correctly;
//    stb=0 and busy=0 next cycle; no done.
//  5 start and ld_en pulses while busy, np_cfg changed mid-run -> ignored; np/inv outputs unchanged; RAM unmodified.
//  6 rst asserted at beat 200 of frame 1 -> outputs reset without a clock; reload, restart, scenario 1 passes.

Source files
------------

// File: rtl/fft_stream_pkg.sv
// ---------------------------------------------------------------------------
// fft_stream_pkg
// Shared types and helpers for the FFT frame streamer.
//   state_t    : playback FSM states
//   frame_len  : frame length for a given np and base log2 size
//   *_DEF      : default widths used by the streamer and its sample RAM
// ---------------------------------------------------------------------------
package fft_stream_pkg;

   localparam int DW_DEF         = 16;
   localparam int NP_W_DEF       = 2;
   localparam int BASE_LOG2N_DEF = 6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      STREAM = 2'd2,
      GAP    = 2'd3
   } state_t;

   // Frame length N = 2^(base + np).
   function automatic int unsigned frame_len(input int unsigned np, input int unsigned base);
      return 32'd1 << (base + np);
   endfunction

endpackage

// File: rtl/fft_sample_ram.sv
// ---------------------------------------------------------------------------
// fft_sample_ram
// Simple dual-port sample store, 2^AW words of WW bits, one write port and
// one read port with a registered read (data valid the cycle after re).
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   re     in  read enable
//   raddr  in  read address
//   rdata  out read data, updated on the edge that samples re
// ---------------------------------------------------------------------------
module fft_sample_ram
   import fft_stream_pkg::*;
#(
   parameter int AW = 9,
   parameter int WW = 2 * DW_DEF
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [WW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [WW-1:0] rdata
);

   logic [WW-1:0] mem [0:(1<<AW)-1];
   logic [WW-1:0] rdata_q;

   // No reset on the array or read register so the store maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fft_frame_streamer.sv
// ---------------------------------------------------------------------------
// fft_frame_streamer
// Plays a preloaded frame of complex samples into the FFT input port.
//   clk, rst           clock, asynchronous active-high reset
//   ld_en/ld_addr/...  host load port into the sample RAM (blocked while busy)
//   start, abort       playback control; abort has priority
//   np_cfg, inv_cfg,
//   rep_cfg, gap_cfg   playback configuration, sampled at an accepted start
//   ready              downstream accepts the current beat
//   stb, sop_in, eop,
//   x_re, x_im         output beat
//   inv, np            configuration latched at start
//   busy, done         playback in progress / pulse after final eop transfer
//   frame_cnt          frames completed since start
// ---------------------------------------------------------------------------
module fft_frame_streamer
   import fft_stream_pkg::*;
#(
   parameter int DW         = DW_DEF,
   parameter int NP_W       = NP_W_DEF,
   parameter int BASE_LOG2N = BASE_LOG2N_DEF,
   parameter int REP_W      = 8,
   parameter int GAP_W      = 8,
   localparam int MAX_LOG2N = BASE_LOG2N + (1 << NP_W) - 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ld_en,
   input  logic [MAX_LOG2N-1:0] ld_addr,
   input  logic [DW-1:0]        ld_re,
   input  logic [DW-1:0]        ld_im,
   input  logic                 start,
   input  logic                 abort,
   input  logic [NP_W-1:0]      np_cfg,
   input  logic                 inv_cfg,
   input  logic [REP_W-1:0]     rep_cfg,
   input  logic [GAP_W-1:0]     gap_cfg,
   input  logic                 ready,
   output logic                 stb,
   output logic                 sop_in,
   output logic                 eop,
   output logic [DW-1:0]        x_re,
   output logic [DW-1:0]        x_im,
   output logic                 inv,
   output logic [NP_W-1:0]      np,
   output logic                 busy,
   output logic                 done,
   output logic [REP_W-1:0]     frame_cnt
);

   localparam int AW = MAX_LOG2N;

   state_t            state_q, state_d;
   logic [NP_W-1:0]   np_q, np_d;
   logic              inv_q, inv_d;
   logic [REP_W-1:0]  rep_q, rep_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic [REP_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [REP_W-1:0]  rd_frm_q, rd_frm_d;
   logic [AW-1:0]     rd_addr_q, rd_addr_d;
   logic              rd_hold_q, rd_hold_d;
   logic              rd_vld_q, rd_vld_d;
   logic              rd_sop_q, rd_sop_d;
   logic              rd_eop_q, rd_eop_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [DW-1:0]     b0_re_q, b0_re_d, b0_im_q, b0_im_d;
   logic [DW-1:0]     b1_re_q, b1_re_d, b1_im_q, b1_im_d;
   logic              b0_sop_q, b0_sop_d, b0_eop_q, b0_eop_d;
   logic              b1_sop_q, b1_sop_d, b1_eop_q, b1_eop_d;
   logic              stb_q, stb_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   logic [AW-1:0]     addr_mask;
   logic [2*DW-1:0]   ram_rdata;
   logic              ram_we;
   logic              rd_en;
   logic              pop, eop_xfer, last_frame, rd_last_frame, space;
   logic              stream_issue, gap_issue;
   logic [1:0]        cnt_pop;
   logic [2:0]        occ;

   // Upper address bits are masked off so only the selected frame is read.
   assign addr_mask = AW'(frame_len(32'(np_q), 32'(BASE_LOG2N)) - 32'd1);

   assign pop           = stb_q && ready;
   assign eop_xfer      = pop && b0_eop_q;
   assign last_frame    = (rep_q != '0) && ((frame_cnt_q + REP_W'(1)) == rep_q);
   assign rd_last_frame = (rep_q != '0) && ((rd_frm_q + REP_W'(1)) == rep_q);

   // A read issued now lands in the buffer one cycle after next; only issue
   // it if the buffer is guaranteed to have room even if nothing pops then.
   assign occ   = {1'b0, cnt_q} - {2'b00, pop} + {2'b00, rd_vld_q};
   assign space = (occ <= 3'd1);

   assign ram_we = ld_en && !busy_q;

   fft_sample_ram #(
      .AW (AW),
      .WW (2*DW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ld_addr),
      .wdata ({ld_re, ld_im}),
      .re    (rd_en),
      .raddr (rd_addr_q),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_d      = state_q;
      np_d         = np_q;
      inv_d        = inv_q;
      rep_d        = rep_q;
      gap_d        = gap_q;
      gap_cnt_d    = gap_cnt_q;
      frame_cnt_d  = frame_cnt_q;
      rd_frm_d     = rd_frm_q;
      rd_addr_d    = rd_addr_q;
      rd_hold_d    = rd_hold_q;
      done_d       = 1'b0;
      stream_issue = 1'b0;
      gap_issue    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               np_d        = np_cfg;
               inv_d       = inv_cfg;
               rep_d       = rep_cfg;
               gap_d       = gap_cfg;
               frame_cnt_d = '0;
               rd_frm_d    = '0;
               rd_addr_d   = '0;
               rd_hold_d   = 1'b0;
               state_d     = PRIME;
            end
         end
         PRIME, STREAM: begin
            stream_issue = !rd_hold_q && space;
            if (state_q == PRIME) begin
               state_d = STREAM;
            end
            if (eop_xfer) begin
               frame_cnt_d = frame_cnt_q + 1'b1;
               if (last_frame) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else if (gap_q == GAP_W'(1)) begin
                  // One idle cycle: the sop read must go out alongside the eop transfer.
                  gap_issue = 1'b1;
               end else if (gap_q != '0) begin
                  // Read of addr 0 is issued two cycles before the sop beat is due.
                  state_d   = GAP;
                  gap_cnt_d = gap_q - GAP_W'(2);
               end
            end
         end
         GAP: begin
            if (gap_cnt_q == '0) begin
               gap_issue = 1'b1;
               state_d   = STREAM;
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Read side: walks the frame, wraps to 0 and, unless frames run
      // back-to-back, parks until the eop side releases the next frame.
      rd_en    = stream_issue || gap_issue;
      rd_vld_d = rd_en;
      rd_sop_d = rd_en && (rd_addr_q == '0);
      rd_eop_d = rd_en && (rd_addr_q == addr_mask);
      if (gap_issue) begin
         rd_hold_d = 1'b0;
      end
      if (rd_en) begin
         rd_addr_d = (rd_addr_q + 1'b1) & addr_mask;
         if (rd_addr_q == addr_mask) begin
            rd_frm_d  = rd_frm_q + 1'b1;
            rd_hold_d = (gap_q != '0) || rd_last_frame;
         end
      end

      // Two-entry buffer; entry 0 is the presented beat.
      b0_re_d  = b0_re_q;
      b0_im_d  = b0_im_q;
      b0_sop_d = b0_sop_q;
      b0_eop_d = b0_eop_q;
      b1_re_d  = b1_re_q;
      b1_im_d  = b1_im_q;
      b1_sop_d = b1_sop_q;
      b1_eop_d = b1_eop_q;
      cnt_pop  = cnt_q - {1'b0, pop};
      if (pop) begin
         b0_re_d  = b1_re_q;
         b0_im_d  = b1_im_q;
         b0_sop_d = b1_sop_q;
         b0_eop_d = b1_eop_q;
      end
      if (rd_vld_q) begin
         if (cnt_pop == 2'd0) begin
            b0_re_d  = ram_rdata[2*DW-1:DW];
            b0_im_d  = ram_rdata[DW-1:0];
            b0_sop_d = rd_sop_q;
            b0_eop_d = rd_eop_q;
         end else begin
            b1_re_d  = ram_rdata[2*DW-1:DW];
            b1_im_d  = ram_rdata[DW-1:0];
            b1_sop_d = rd_sop_q;
            b1_eop_d = rd_eop_q;
         end
      end
      cnt_d = cnt_pop + {1'b0, rd_vld_q};

      if (abort) begin
         state_d     = IDLE;
         cnt_d       = 2'd0;
         rd_vld_d    = 1'b0;
         frame_cnt_d = frame_cnt_q;
         done_d      = 1'b0;
      end

      // Markers are only meaningful with stb; keep them low when empty.
      if (cnt_d == 2'd0) begin
         b0_sop_d = 1'b0;
         b0_eop_d = 1'b0;
      end
      stb_d  = (cnt_d != 2'd0);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         np_q        <= '0;
         inv_q       <= 1'b0;
         rep_q       <= '0;
         gap_q       <= '0;
         gap_cnt_q   <= '0;
         frame_cnt_q <= '0;
         rd_frm_q    <= '0;
         rd_addr_q   <= '0;
         rd_hold_q   <= 1'b0;
         rd_vld_q    <= 1'b0;
         rd_sop_q    <= 1'b0;
         rd_eop_q    <= 1'b0;
         cnt_q       <= 2'd0;
         b0_re_q     <= '0;
         b0_im_q     <= '0;
         b0_sop_q    <= 1'b0;
         b0_eop_q    <= 1'b0;
         b1_re_q     <= '0;
         b1_im_q     <= '0;
         b1_sop_q    <= 1'b0;
         b1_eop_q    <= 1'b0;
         stb_q       <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         np_q        <= np_d;
         inv_q       <= inv_d;
         rep_q       <= rep_d;
         gap_q       <= gap_d;
         gap_cnt_q   <= gap_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         rd_frm_q    <= rd_frm_d;
         rd_addr_q   <= rd_addr_d;
         rd_hold_q   <= rd_hold_d;
         rd_vld_q    <= rd_vld_d;
         rd_sop_q    <= rd_sop_d;
         rd_eop_q    <= rd_eop_d;
         cnt_q       <= cnt_d;
         b0_re_q     <= b0_re_d;
         b0_im_q     <= b0_im_d;
         b0_sop_q    <= b0_sop_d;
         b0_eop_q    <= b0_eop_d;
         b1_re_q     <= b1_re_d;
         b1_im_q     <= b1_im_d;
         b1_sop_q    <= b1_sop_d;
         b1_eop_q    <= b1_eop_d;
         stb_q       <= stb_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   assign stb       = stb_q;
   assign sop_in    = b0_sop_q;
   assign eop       = b0_eop_q;
   assign x_re      = b0_re_q;
   assign x_im      = b0_im_q;
   assign inv       = inv_q;
   assign np        = np_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_streamer.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_streamer
// Directed bench for fft_frame_streamer: ramp frame re=i, im=-i, played
// with various sizes, repeat counts, gaps, backpressure, abort and reset.
// ---------------------------------------------------------------------------
module tb_fft_frame_streamer;

   logic        clk;
   logic        rst;
   logic        ld_en;
   logic [8:0]  ld_addr;
   logic [15:0] ld_re;
   logic [15:0] ld_im;
   logic        start;
   logic        abort;
   logic [1:0]  np_cfg;
   logic        inv_cfg;
   logic [7:0]  rep_cfg;
   logic [7:0]  gap_cfg;
   logic        ready;
   logic        stb;
   logic        sop_in;
   logic        eop;
   logic [15:0] x_re;
   logic [15:0] x_im;
   logic        inv;
   logic [1:0]  np;
   logic        busy;
   logic        done;
   logic [7:0]  frame_cnt;

   int checks   = 0;
   int failures = 0;

   fft_frame_streamer dut (
      .clk       (clk),
      .rst       (rst),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_re     (ld_re),
      .ld_im     (ld_im),
      .start     (start),
      .abort     (abort),
      .np_cfg    (np_cfg),
      .inv_cfg   (inv_cfg),
      .rep_cfg   (rep_cfg),
      .gap_cfg   (gap_cfg),
      .ready     (ready),
      .stb       (stb),
      .sop_in    (sop_in),
      .eop       (eop),
      .x_re      (x_re),
      .x_im      (x_im),
      .inv       (inv),
      .np        (np),
      .busy      (busy),
      .done      (done),
      .frame_cnt (frame_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ramp();
      for (int i = 0; i < 512; i++) begin
         ld_en   = 1'b1;
         ld_addr = 9'(i);
         ld_re   = 16'(i);
         ld_im   = 16'(-i);
         tick();
      end
      ld_en = 1'b0;
      $display("load ramp 512 words");
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_stb"},  64'(stb),       64'(0));
      check({tag, "_sop"},  64'(sop_in),    64'(0));
      check({tag, "_eop"},  64'(eop),       64'(0));
      check({tag, "_busy"}, 64'(busy),      64'(0));
      check({tag, "_done"}, 64'(done),      64'(0));
      check({tag, "_xre"},  64'(x_re),      64'(0));
      check({tag, "_xim"},  64'(x_im),      64'(0));
      check({tag, "_fcnt"}, 64'(frame_cnt), 64'(0));
      check({tag, "_inv"},  64'(inv),       64'(0));
      check({tag, "_np"},   64'(np),        64'(0));
   endtask

   // Start pulse; stb must appear exactly two cycles after the start edge.
   task automatic do_start(input int n_p, input int i_v, input int rep, input int gap);
      np_cfg  = 2'(n_p);
      inv_cfg = 1'(i_v);
      rep_cfg = 8'(rep);
      gap_cfg = 8'(gap);
      ready   = 1'b1;
      start   = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", 64'(busy), 64'(1));
      check("start_stb0", 64'(stb), 64'(0));
      tick();
      check("start_stb1", 64'(stb), 64'(0));
      tick();
      check("start_stb2", 64'(stb), 64'(1));
   endtask

   // Consumes beats and checks them against the ramp model.
   task automatic run_stream(input int n_len, input int n_frames, input int gap, input bit rnd,
                             input int stop_at, input bit stop_rst, input int poke_at,
                             input int exp_np, input int exp_inv);
      int beat = 0;
      int total = 0;
      int frm = 0;
      int idle = 0;
      int cyc = 0;
      bit in_gap = 1'b0;
      bit held = 1'b0;
      logic [33:0] snap = '0;
      while (1) begin
         if (cyc > 20000) begin
            check("timeout", 64'(cyc), 64'(0));
            break;
         end
         cyc++;
         if (held) begin
            check("stall_stb", 64'(stb), 64'(1));
            check("stall_hold", 64'({x_re, x_im, sop_in, eop}), 64'(snap));
            held = 1'b0;
         end
         if (stb) begin
            if (in_gap) begin
               check("gap_len", 64'(idle), 64'(gap));
               in_gap = 1'b0;
            end
            check("x_re", 64'(x_re), 64'(beat));
            check("x_im", 64'(x_im), 64'((-beat) & 32'h0000_ffff));
            check("sop", 64'(sop_in), 64'(beat == 0));
            check("eop", 64'(eop), 64'(beat == n_len - 1));
            if (beat == 0 || beat == n_len - 1) begin
               check("np_out", 64'(np), 64'(exp_np));
               check("inv_out", 64'(inv), 64'(exp_inv));
            end
            if (total == stop_at) begin
               if (stop_rst) begin
                  #3;
                  rst = 1'b1;
                  #1;
                  check_reset_outputs("async_rst");
                  $display("reset at beat %0d", total);
               end else begin
                  abort = 1'b1;
                  ready = 1'b0;
                  tick();
                  abort = 1'b0;
                  ready = 1'b1;
                  check("abort_stb", 64'(stb), 64'(0));
                  check("abort_busy", 64'(busy), 64'(0));
                  check("abort_done", 64'(done), 64'(0));
                  check("abort_fcnt", 64'(frame_cnt), 64'(frm & 255));
                  $display("abort at beat %0d frames=%0d", total, frm);
               end
               break;
            end
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (total == poke_at) begin
               start   = 1'b1;
               ld_en   = 1'b1;
               ld_addr = 9'd5;
               ld_re   = 16'hdead;
               ld_im   = 16'hbeef;
               np_cfg  = 2'(exp_np + 1);
               inv_cfg = ~1'(exp_inv);
            end
            if (ready) begin
               total++;
               beat++;
               if (beat == n_len) begin
                  beat = 0;
                  frm++;
                  tick();
                  start = 1'b0;
                  ld_en = 1'b0;
                  check("frame_cnt", 64'(frame_cnt), 64'(frm & 255));
                  $display("frame %0d done len=%0d frame_cnt=%0d", frm, n_len, frame_cnt);
                  if (n_frames != 0 && frm == n_frames) begin
                     check("done_pulse", 64'(done), 64'(1));
                     check("end_busy", 64'(busy), 64'(0));
                     check("end_stb", 64'(stb), 64'(0));
                     tick();
                     check("done_clear", 64'(done), 64'(0));
                     break;
                  end
                  check("done_early", 64'(done), 64'(0));
                  in_gap = 1'b1;
                  idle   = 0;
                  continue;
               end
            end else begin
               held = 1'b1;
               snap = {x_re, x_im, sop_in, eop};
            end
         end else begin
            if (in_gap) begin
               idle++;
            end else begin
               check("stb_drop", 64'(stb), 64'(1));
               break;
            end
         end
         tick();
         start = 1'b0;
         ld_en = 1'b0;
      end
   endtask

   initial begin
      rst     = 1'b1;
      ld_en   = 1'b0;
      ld_addr = '0;
      ld_re   = '0;
      ld_im   = '0;
      start   = 1'b0;
      abort   = 1'b0;
      np_cfg  = '0;
      inv_cfg = 1'b0;
      rep_cfg = '0;
      gap_cfg = '0;
      ready   = 1'b1;
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      load_ramp();

      // start and abort together: abort wins
      np_cfg = 2'd3;
      start  = 1'b1;
      abort  = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("sa_busy", 64'(busy), 64'(0));
      tick();
      check("sa_stb", 64'(stb), 64'(0));
      $display("start+abort ignored");

      // 1: full 512 frame, ready=1
      do_start(3, 0, 1, 0);
      run_stream(512, 1, 0, 1'b0, -1, 1'b0, -1, 3, 0);

      // 2: same with random backpressure
      do_start(3, 0, 1, 0);
      run_stream(512, 1, 0, 1'b1, -1, 1'b0, -1, 3, 0);

      // 5: start/ld_en/cfg changes while busy are ignored
      do_start(1, 1, 1, 0);
      run_stream(128, 1, 0, 1'b0, -1, 1'b0, 50, 1, 1);
      check("t5_np_after", 64'(np), 64'(1));
      check("t5_inv_after", 64'(inv), 64'(1));

      // 3: three 64-beat frames with 4-cycle gaps (also re-reads addr 5)
      do_start(0, 0, 3, 4);
      run_stream(64, 3, 4, 1'b0, -1, 1'b0, -1, 0, 0);

      // 4: continuous 128-beat frames, abort with beat 1000 presented
      do_start(1, 0, 0, 0);
      run_stream(128, 0, 0, 1'b0, 1000, 1'b0, -1, 1, 0);
      check("t4_fcnt", 64'(frame_cnt), 64'(7));
      tick();
      check("t4_done", 64'(done), 64'(0));

      // 6: asynchronous reset at beat 200, then reload and replay
      do_start(3, 1, 1, 0);
      run_stream(512, 1, 0, 1'b0, 200, 1'b1, -1, 3, 1);
      tick();
      tick();
      rst = 1'b0;
      tick();
      load_ramp();
      do_start(3, 0, 1, 0);
      run_stream(512, 1, 0, 1'b0, -1, 1'b0, -1, 3, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
